// File: rtl/alu_exec_pkg.sv
// Shared op encodings, widths and shift control payload for the ALU execute slice.
package alu_exec_pkg;

    localparam int unsigned OP_SIZE_LOG  = 5;
    localparam int unsigned ROB_SIZE_LOG = 4;
    localparam int unsigned XLEN         = 32;
    localparam int unsigned SHAMT_W      = 5;

    localparam logic [OP_SIZE_LOG-1:0] OP_NOP   = 5'd0;
    localparam logic [OP_SIZE_LOG-1:0] OP_LUI   = 5'd1;
    localparam logic [OP_SIZE_LOG-1:0] OP_AUIPC = 5'd2;
    localparam logic [OP_SIZE_LOG-1:0] OP_JAL   = 5'd3;
    localparam logic [OP_SIZE_LOG-1:0] OP_JALR  = 5'd4;
    localparam logic [OP_SIZE_LOG-1:0] OP_BEQ   = 5'd5;
    localparam logic [OP_SIZE_LOG-1:0] OP_BNE   = 5'd6;
    localparam logic [OP_SIZE_LOG-1:0] OP_BLT   = 5'd7;
    localparam logic [OP_SIZE_LOG-1:0] OP_BGE   = 5'd8;
    localparam logic [OP_SIZE_LOG-1:0] OP_BLTU  = 5'd9;
    localparam logic [OP_SIZE_LOG-1:0] OP_BGEU  = 5'd10;
    localparam logic [OP_SIZE_LOG-1:0] OP_ADD   = 5'd11;
    localparam logic [OP_SIZE_LOG-1:0] OP_SUB   = 5'd12;
    localparam logic [OP_SIZE_LOG-1:0] OP_SLL   = 5'd13;
    localparam logic [OP_SIZE_LOG-1:0] OP_SLT   = 5'd14;
    localparam logic [OP_SIZE_LOG-1:0] OP_SLTU  = 5'd15;
    localparam logic [OP_SIZE_LOG-1:0] OP_XOR   = 5'd16;
    localparam logic [OP_SIZE_LOG-1:0] OP_SRL   = 5'd17;
    localparam logic [OP_SIZE_LOG-1:0] OP_SRA   = 5'd18;
    localparam logic [OP_SIZE_LOG-1:0] OP_OR    = 5'd19;
    localparam logic [OP_SIZE_LOG-1:0] OP_AND   = 5'd20;
    localparam logic [OP_SIZE_LOG-1:0] OP_ADDI  = 5'd21;
    localparam logic [OP_SIZE_LOG-1:0] OP_SLTI  = 5'd22;
    localparam logic [OP_SIZE_LOG-1:0] OP_SLTIU = 5'd23;
    localparam logic [OP_SIZE_LOG-1:0] OP_XORI  = 5'd24;
    localparam logic [OP_SIZE_LOG-1:0] OP_ORI   = 5'd25;
    localparam logic [OP_SIZE_LOG-1:0] OP_ANDI  = 5'd26;
    localparam logic [OP_SIZE_LOG-1:0] OP_SLLI  = 5'd27;
    localparam logic [OP_SIZE_LOG-1:0] OP_SRLI  = 5'd28;
    localparam logic [OP_SIZE_LOG-1:0] OP_SRAI  = 5'd29;

    // Direction and fill control handed to the iterative shifter.
    typedef struct packed {
        logic left;
        logic arith;
    } shift_ctrl_t;

endpackage

// File: rtl/alu_exec_shift_unit.sv
// Iterative one-bit-per-cycle shifter: operand register, counter, direction control.
module alu_shift_unit
    import alu_exec_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                rdy,
    input  logic                flush,
    input  logic                load,
    input  logic [XLEN-1:0]     operand,
    input  logic [SHAMT_W-1:0]  shamt,
    input  shift_ctrl_t         ctrl,
    output logic [XLEN-1:0]     step_c,
    output logic                last_c
);

    logic [XLEN-1:0]    opnd;
    logic [SHAMT_W-1:0] cnt;
    shift_ctrl_t        ctrl_q;

    // One shift step applied to the held operand.
    always_comb begin
        step_c = opnd;
        if (ctrl_q.left) begin
            step_c = {opnd[XLEN-2:0], 1'b0};
        end else begin
            step_c = {ctrl_q.arith & opnd[XLEN-1], opnd[XLEN-1:1]};
        end
        last_c = (cnt == SHAMT_W'(1));
    end

    // Load on acceptance, then shift and count down while frozen on !rdy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opnd   <= '0;
            cnt    <= '0;
            ctrl_q <= '0;
        end else if (rdy) begin
            if (flush) begin
                cnt <= '0;
            end else if (load) begin
                opnd   <= operand;
                cnt    <= shamt;
                ctrl_q <= ctrl;
            end else if (cnt != '0) begin
                opnd <= step_c;
                cnt  <= cnt - SHAMT_W'(1);
            end
        end
    end

endmodule

// File: rtl/alu_exec.sv
// RV32I execute unit: single-cycle compute, iterative shifts, branch resolution.
module alu_exec
    import alu_exec_pkg::*;
#(
    parameter int unsigned OP_W  = OP_SIZE_LOG,
    parameter int unsigned ROB_W = ROB_SIZE_LOG
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             rdy,
    input  logic             ALU_enable,
    input  logic [OP_W-1:0]  op_to_ALU,
    input  logic [31:0]      vj_to_ALU,
    input  logic [31:0]      vk_to_ALU,
    input  logic [31:0]      imm_to_ALU,
    input  logic [ROB_W-1:0] robid_to_ALU,
    input  logic [31:0]      curpc_to_ALU,
    input  logic             pred_fail_flag,
    output logic             ALU_valid,
    output logic [31:0]      ALU_value,
    output logic [ROB_W-1:0] ALU_robid,
    output logic             ALU_jump,
    output logic [31:0]      ALU_target_pc,
    output logic             alu_ready
);

    typedef enum logic [0:0] {ST_IDLE, ST_SHIFT} state_t;

    state_t                  state, next_state;
    logic [OP_SIZE_LOG-1:0]  op_c;
    logic [31:0]             rhs_c, pc4_c, result_c, target_c, shift_step_c;
    logic                    jump_c, cond_c, is_branch_c, is_shift_c, use_imm_c;
    logic [SHAMT_W-1:0]      shamt_c;
    shift_ctrl_t             sctrl_c;
    logic                    accept_c, flush_c, load_c, finish_c, shift_last_c;

    assign op_c      = OP_SIZE_LOG'(op_to_ALU);
    assign pc4_c     = curpc_to_ALU + 32'd4;
    assign use_imm_c = op_c inside {OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI, OP_ANDI,
                                    OP_SLLI, OP_SRLI, OP_SRAI};
    assign rhs_c     = use_imm_c ? imm_to_ALU : vk_to_ALU;
    assign alu_ready = (state == ST_IDLE);
    assign flush_c   = rdy && pred_fail_flag;
    assign accept_c  = rdy && ALU_enable && alu_ready && !pred_fail_flag;

    // Combinational compute of value, branch condition and next PC.
    always_comb begin
        result_c    = '0;
        jump_c      = 1'b0;
        target_c    = pc4_c;
        cond_c      = 1'b0;
        is_branch_c = 1'b0;
        is_shift_c  = 1'b0;
        shamt_c     = rhs_c[SHAMT_W-1:0];
        sctrl_c     = '0;
        case (op_c)
            OP_LUI:   result_c = imm_to_ALU;
            OP_AUIPC: result_c = curpc_to_ALU + imm_to_ALU;
            OP_JAL: begin
                result_c = pc4_c;
                jump_c   = 1'b1;
                target_c = curpc_to_ALU + imm_to_ALU;
            end
            OP_JALR: begin
                result_c = pc4_c;
                jump_c   = 1'b1;
                target_c = (vj_to_ALU + imm_to_ALU) & ~32'd1;
            end
            OP_BEQ:  begin is_branch_c = 1'b1; cond_c = (vj_to_ALU == vk_to_ALU); end
            OP_BNE:  begin is_branch_c = 1'b1; cond_c = (vj_to_ALU != vk_to_ALU); end
            OP_BLT:  begin is_branch_c = 1'b1; cond_c = ($signed(vj_to_ALU) <  $signed(vk_to_ALU)); end
            OP_BGE:  begin is_branch_c = 1'b1; cond_c = ($signed(vj_to_ALU) >= $signed(vk_to_ALU)); end
            OP_BLTU: begin is_branch_c = 1'b1; cond_c = (vj_to_ALU <  vk_to_ALU); end
            OP_BGEU: begin is_branch_c = 1'b1; cond_c = (vj_to_ALU >= vk_to_ALU); end
            OP_ADD, OP_ADDI:   result_c = vj_to_ALU + rhs_c;
            OP_SUB:            result_c = vj_to_ALU - rhs_c;
            OP_SLT, OP_SLTI:   result_c = {31'b0, $signed(vj_to_ALU) < $signed(rhs_c)};
            OP_SLTU, OP_SLTIU: result_c = {31'b0, vj_to_ALU < rhs_c};
            OP_XOR, OP_XORI:   result_c = vj_to_ALU ^ rhs_c;
            OP_OR, OP_ORI:     result_c = vj_to_ALU | rhs_c;
            OP_AND, OP_ANDI:   result_c = vj_to_ALU & rhs_c;
            OP_SLL, OP_SLLI: begin is_shift_c = 1'b1; sctrl_c.left  = 1'b1; result_c = vj_to_ALU; end
            OP_SRL, OP_SRLI: begin is_shift_c = 1'b1; result_c = vj_to_ALU; end
            OP_SRA, OP_SRAI: begin is_shift_c = 1'b1; sctrl_c.arith = 1'b1; result_c = vj_to_ALU; end
            default: result_c = '0;
        endcase
        if (is_branch_c) begin
            result_c = {31'b0, cond_c};
            jump_c   = cond_c;
            target_c = cond_c ? (curpc_to_ALU + imm_to_ALU) : pc4_c;
        end
    end

    alu_shift_unit u_shift (
        .clk     (clk),
        .rst_n   (rst_n),
        .rdy     (rdy),
        .flush   (flush_c),
        .load    (load_c),
        .operand (vj_to_ALU),
        .shamt   (shamt_c),
        .ctrl    (sctrl_c),
        .step_c  (shift_step_c),
        .last_c  (shift_last_c)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= next_state;
    end

    // Next state, shifter load and shift completion.
    always_comb begin
        next_state = state;
        load_c     = 1'b0;
        finish_c   = 1'b0;
        if (flush_c) begin
            next_state = ST_IDLE;
        end else if (rdy) begin
            case (state)
                ST_IDLE: begin
                    if (accept_c && is_shift_c && (shamt_c != '0)) begin
                        next_state = ST_SHIFT;
                        load_c     = 1'b1;
                    end
                end
                ST_SHIFT: begin
                    if (shift_last_c) begin
                        next_state = ST_IDLE;
                        finish_c   = 1'b1;
                    end
                end
                default: next_state = ST_IDLE;
            endcase
        end
    end

    // Broadcast and branch output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ALU_valid     <= 1'b0;
            ALU_value     <= '0;
            ALU_robid     <= '0;
            ALU_jump      <= 1'b0;
            ALU_target_pc <= '0;
        end else if (rdy) begin
            ALU_valid <= 1'b0;
            if (accept_c) begin
                ALU_robid     <= robid_to_ALU;
                ALU_jump      <= jump_c;
                ALU_target_pc <= target_c;
                if (!load_c) begin
                    ALU_valid <= 1'b1;
                    ALU_value <= result_c;
                end
            end else if (finish_c) begin
                ALU_valid <= 1'b1;
                ALU_value <= shift_step_c;
            end
        end
    end

endmodule

// File: tb/tb_alu_exec.sv
// Scoreboard bench for alu_exec: random and directed dispatches against a reference model.
module tb_alu_exec;
    import alu_exec_pkg::*;

    localparam int unsigned OW = OP_SIZE_LOG;
    localparam int unsigned RW = ROB_SIZE_LOG;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          rdy = 1'b1;
    logic          ALU_enable = 1'b0;
    logic [OW-1:0] op_to_ALU = '0;
    logic [31:0]   vj_to_ALU = '0, vk_to_ALU = '0, imm_to_ALU = '0, curpc_to_ALU = '0;
    logic [RW-1:0] robid_to_ALU = '0;
    logic          pred_fail_flag = 1'b0;
    logic          ALU_valid, ALU_jump, alu_ready;
    logic [31:0]   ALU_value, ALU_target_pc;
    logic [RW-1:0] ALU_robid;

    alu_exec dut (
        .clk(clk), .rst_n(rst_n), .rdy(rdy), .ALU_enable(ALU_enable),
        .op_to_ALU(op_to_ALU), .vj_to_ALU(vj_to_ALU), .vk_to_ALU(vk_to_ALU),
        .imm_to_ALU(imm_to_ALU), .robid_to_ALU(robid_to_ALU), .curpc_to_ALU(curpc_to_ALU),
        .pred_fail_flag(pred_fail_flag), .ALU_valid(ALU_valid), .ALU_value(ALU_value),
        .ALU_robid(ALU_robid), .ALU_jump(ALU_jump), .ALU_target_pc(ALU_target_pc),
        .alu_ready(alu_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]   value;
        logic          jump;
        logic [31:0]   target;
        logic [RW-1:0] robid;
        int            due;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;
    int   edge_cnt = 0;
    bit   last_active = 1'b0;
    bit   m_busy = 1'b0;
    int   m_due = 0;
    logic [OW-1:0] op_list [29];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at edge %0d", name, act, req, edge_cnt);
        end
    endtask

    // Reference model: RV32I semantics straight from the op definitions.
    task automatic ref_model(input logic [OW-1:0] op, input logic [31:0] vj, vk, imm, pc,
                             output logic [31:0] v, output logic j, output logic [31:0] t,
                             output int n);
        logic cond;
        logic br;
        cond = 1'b0; br = 1'b0;
        v = 32'd0; j = 1'b0; t = pc + 32'd4; n = 0;
        case (op)
            OP_LUI:   v = imm;
            OP_AUIPC: v = pc + imm;
            OP_JAL:   begin v = pc + 32'd4; j = 1'b1; t = pc + imm; end
            OP_JALR:  begin v = pc + 32'd4; j = 1'b1; t = (vj + imm) & 32'hFFFF_FFFE; end
            OP_BEQ:   begin br = 1'b1; cond = (vj == vk); end
            OP_BNE:   begin br = 1'b1; cond = (vj != vk); end
            OP_BLT:   begin br = 1'b1; cond = ($signed(vj) < $signed(vk)); end
            OP_BGE:   begin br = 1'b1; cond = !($signed(vj) < $signed(vk)); end
            OP_BLTU:  begin br = 1'b1; cond = (vj < vk); end
            OP_BGEU:  begin br = 1'b1; cond = !(vj < vk); end
            OP_ADD:   v = vj + vk;
            OP_SUB:   v = vj - vk;
            OP_SLT:   v = ($signed(vj) < $signed(vk)) ? 32'd1 : 32'd0;
            OP_SLTU:  v = (vj < vk) ? 32'd1 : 32'd0;
            OP_XOR:   v = vj ^ vk;
            OP_OR:    v = vj | vk;
            OP_AND:   v = vj & vk;
            OP_ADDI:  v = vj + imm;
            OP_SLTI:  v = ($signed(vj) < $signed(imm)) ? 32'd1 : 32'd0;
            OP_SLTIU: v = (vj < imm) ? 32'd1 : 32'd0;
            OP_XORI:  v = vj ^ imm;
            OP_ORI:   v = vj | imm;
            OP_ANDI:  v = vj & imm;
            OP_SLL:   begin n = int'(vk[4:0]);  v = vj << n; end
            OP_SRL:   begin n = int'(vk[4:0]);  v = vj >> n; end
            OP_SRA:   begin n = int'(vk[4:0]);  v = $signed(vj) >>> n; end
            OP_SLLI:  begin n = int'(imm[4:0]); v = vj << n; end
            OP_SRLI:  begin n = int'(imm[4:0]); v = vj >> n; end
            OP_SRAI:  begin n = int'(imm[4:0]); v = $signed(vj) >>> n; end
            default:  v = 32'd0;
        endcase
        if (br) begin
            v = cond ? 32'd1 : 32'd0;
            j = cond;
            t = cond ? pc + imm : pc + 32'd4;
        end
    endtask

    function automatic bit model_ready();
        return !m_busy || (m_due <= edge_cnt);
    endfunction

    // Advance one clock with the applied inputs and update the model for that edge.
    task automatic cycle();
        bit ready_before;
        bit active;
        exp_t e;
        logic [31:0] v, t;
        logic j;
        int n;
        ready_before = model_ready();
        if (rst_n) check("alu_ready", 32'(alu_ready), 32'(ready_before));
        @(posedge clk);
        active = rdy && rst_n;
        if (active) begin
            edge_cnt++;
            if (pred_fail_flag) begin
                for (int i = sb.size() - 1; i >= 0; i--)
                    if (sb[i].due >= edge_cnt) sb.delete(i);
                m_busy = 1'b0;
            end else if (ALU_enable && ready_before) begin
                ref_model(op_to_ALU, vj_to_ALU, vk_to_ALU, imm_to_ALU, curpc_to_ALU, v, j, t, n);
                e.value = v; e.jump = j; e.target = t; e.robid = robid_to_ALU; e.due = edge_cnt + n;
                sb.push_back(e);
                if (n > 0) begin m_busy = 1'b1; m_due = edge_cnt + n; end
            end
        end
        last_active = active;
        #1;
    endtask

    task automatic drive(input logic en, input logic [OW-1:0] op, input logic [31:0] vj, vk, imm, pc,
                         input logic [RW-1:0] rob, input logic fl, input logic r);
        ALU_enable = en; op_to_ALU = op; vj_to_ALU = vj; vk_to_ALU = vk; imm_to_ALU = imm;
        curpc_to_ALU = pc; robid_to_ALU = rob; pred_fail_flag = fl; rdy = r;
        cycle();
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) drive(1'b0, OP_ADD, 32'd0, 32'd0, 32'd0, 32'd0, '0, 1'b0, 1'b1);
    endtask

    // Monitor: every freshly updated output is matched against the scoreboard head.
    always @(negedge clk) begin
        if (rst_n && last_active) begin
            if (ALU_valid) begin
                if (sb.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL spurious_valid actual=1 required=0 value=%h at edge %0d", ALU_value, edge_cnt);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("latency_edge", 32'(edge_cnt), 32'(e.due));
                    check("value", ALU_value, e.value);
                    check("jump", 32'(ALU_jump), 32'(e.jump));
                    check("target_pc", ALU_target_pc, e.target);
                    check("robid", 32'(ALU_robid), 32'(e.robid));
                end
            end else if (sb.size() > 0 && sb[0].due <= edge_cnt) begin
                checks++; failures++;
                $display("FAIL missing_valid actual=0 required=1 due=%0d at edge %0d", sb[0].due, edge_cnt);
                void'(sb.pop_front());
            end
        end
    end

    initial begin
        int guard;
        op_list = '{OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU,
                    OP_BGEU, OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA,
                    OP_OR, OP_AND, OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI, OP_ANDI,
                    OP_SLLI, OP_SRLI, OP_SRAI};

        // Reset values.
        #3;
        check("rst_valid", 32'(ALU_valid), 32'd0);
        check("rst_value", ALU_value, 32'd0);
        check("rst_robid", 32'(ALU_robid), 32'd0);
        check("rst_jump", 32'(ALU_jump), 32'd0);
        check("rst_target", ALU_target_pc, 32'd0);
        check("rst_ready", 32'(alu_ready), 32'd1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle(2);

        // ADD wraps modulo 2^32, valid is a single-cycle pulse.
        drive(1'b1, OP_ADD, 32'd7, 32'hFFFF_FFFE, 32'd0, 32'h200, 4'd9, 1'b0, 1'b1);
        check("add_valid", 32'(ALU_valid), 32'd1);
        check("add_value", ALU_value, 32'd5);
        check("add_robid", 32'(ALU_robid), 32'd9);
        idle(1);
        check("add_valid_drop", 32'(ALU_valid), 32'd0);

        // SRAI by 4: busy for 4 cycles, sign-filled result.
        drive(1'b1, OP_SRAI, 32'h8000_0000, 32'd0, 32'd4, 32'h300, 4'd3, 1'b0, 1'b1);
        idle(4);
        check("srai_valid", 32'(ALU_valid), 32'd1);
        check("srai_value", ALU_value, 32'hF800_0000);
        check("srai_ready", 32'(alu_ready), 32'd1);

        // Signed vs unsigned branch on the same operands.
        drive(1'b1, OP_BLT, 32'hFFFF_FFFF, 32'd1, 32'h20, 32'h100, 4'd1, 1'b0, 1'b1);
        check("blt_jump", 32'(ALU_jump), 32'd1);
        check("blt_target", ALU_target_pc, 32'h120);
        check("blt_value", ALU_value, 32'd1);
        drive(1'b1, OP_BLTU, 32'hFFFF_FFFF, 32'd1, 32'h20, 32'h100, 4'd2, 1'b0, 1'b1);
        check("bltu_jump", 32'(ALU_jump), 32'd0);
        check("bltu_target", ALU_target_pc, 32'h104);

        // JALR clears bit 0 of the target.
        drive(1'b1, OP_JALR, 32'h1003, 32'd0, 32'd2, 32'h40, 4'd4, 1'b0, 1'b1);
        check("jalr_value", ALU_value, 32'h44);
        check("jalr_target", ALU_target_pc, 32'h1004);
        check("jalr_jump", 32'(ALU_jump), 32'd1);

        // Flush at the third edge of a 10-bit shift; concurrent dispatch is refused.
        drive(1'b1, OP_SLL, 32'h1, 32'd10, 32'd0, 32'h80, 4'd6, 1'b0, 1'b1);
        idle(2);
        drive(1'b1, OP_ADD, 32'd1, 32'd1, 32'd0, 32'h90, 4'd7, 1'b1, 1'b1);
        check("flush_ready", 32'(alu_ready), 32'd1);
        check("flush_valid", 32'(ALU_valid), 32'd0);
        idle(12);

        // rdy low for 3 cycles mid-shift stretches latency by 3.
        drive(1'b1, OP_SRLI, 32'hF000_0000, 32'd0, 32'd3, 32'hA0, 4'd8, 1'b0, 1'b1);
        drive(1'b0, OP_ADD, 32'd0, 32'd0, 32'd0, 32'd0, '0, 1'b0, 1'b0);
        drive(1'b0, OP_ADD, 32'd0, 32'd0, 32'd0, 32'd0, '0, 1'b0, 1'b0);
        drive(1'b0, OP_ADD, 32'd0, 32'd0, 32'd0, 32'd0, '0, 1'b0, 1'b0);
        check("rdy_hold_busy", 32'(alu_ready), 32'd0);
        idle(2);
        check("rdy_hold_notyet", 32'(ALU_valid), 32'd0);
        idle(1);
        check("rdy_hold_valid", 32'(ALU_valid), 32'd1);
        check("rdy_hold_value", ALU_value, 32'h1E00_0000);
        idle(2);

        // Asynchronous reset mid-shift clears outputs without a clock edge.
        drive(1'b1, OP_SLL, 32'h5, 32'd10, 32'd0, 32'hC0, 4'd5, 1'b0, 1'b1);
        idle(2);
        rst_n = 1'b0;
        #1;
        check("arst_valid", 32'(ALU_valid), 32'd0);
        check("arst_value", ALU_value, 32'd0);
        check("arst_robid", 32'(ALU_robid), 32'd0);
        check("arst_target", ALU_target_pc, 32'd0);
        check("arst_ready", 32'(alu_ready), 32'd1);
        sb.delete();
        m_busy = 1'b0;
        idle(2);
        rst_n = 1'b1;
        idle(14);

        // Randomized traffic with stalls, flushes and protocol-violating strobes.
        for (int it = 0; it < 600; it++) begin
            drive(($urandom % 3) != 0, op_list[$urandom % 29], $urandom, $urandom, $urandom,
                  $urandom, RW'($urandom), ($urandom % 24) == 0, ($urandom % 8) != 0);
        end

        // Drain outstanding work with a bounded wait.
        guard = 0;
        while (sb.size() != 0 && guard < 100) begin
            idle(1);
            guard++;
        end
        if (sb.size() != 0) begin
            checks++; failures++;
            $display("FAIL drain_timeout actual=%0d required=0 pending results", sb.size());
        end
        idle(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
